// File: rtl/uart_pkg.sv
// Shared types and protocol constants for the parameterised UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [7:0] ACK    = 8'hAA;
    localparam logic [7:0] RESEND = 8'hCC;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead read data and registered not-full flag.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;
    logic [CNT_W-1:0] count_n;

    assign do_wr   = wr_en && ready;
    assign do_rd   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_n = count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    // Pointers, occupancy and the ready flag; ready stays low while in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
            ready <= (count_n != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with a write FIFO, optional parity, 1/2 stop bits and RTS hold-off.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter parity_t     PARITY_MODE  = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          USB_RTS,
    output logic                          USB_TX,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W      = $clog2(DATA_BITS + 1);
    localparam logic        HAS_PARITY = (PARITY_MODE != PAR_NONE);
    localparam logic        PAR_FLIP   = (PARITY_MODE == PAR_ODD);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_par
        $error("uart_tx_param: illegal PARITY_MODE");
    end

    state_t                 state;
    state_t                 state_n;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [IDX_W-1:0]       data_idx;
    logic [IDX_W-1:0]       idx_n;
    logic                   stop_idx;
    logic                   stop_n;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_n;
    logic                   par_reg;
    logic                   par_n;
    logic                   tx_n;
    logic                   busy_n;
    logic                   done_n;
    logic [DATA_BITS-1:0]   fifo_rd;
    logic                   bit_end;
    logic                   last_data;
    logic                   last_stop;
    logic                   pop;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .ready   (tx_ready)
    );

    assign bit_end   = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data = (data_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    // RTS is only looked at while idle or on the closing cycle of the last stop bit.
    assign pop = (fifo_count != '0) && !USB_RTS &&
                 ((state == S_IDLE) || (state == S_STOP && bit_end && last_stop));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (pop) state_n = S_START;
            S_START:  if (bit_end) state_n = S_DATA;
            S_DATA:   if (bit_end && last_data) state_n = HAS_PARITY ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_n = S_STOP;
            S_STOP:   if (bit_end && last_stop) state_n = pop ? S_START : S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Next values for the bit timer, shifter and the registered line/status outputs.
    always_comb begin
        cnt_n   = '0;
        shift_n = shift_reg;
        par_n   = par_reg;
        idx_n   = '0;
        stop_n  = 1'b0;
        tx_n    = 1'b1;
        if (state != S_IDLE && !bit_end) cnt_n = bit_cnt + CNT_W'(1);
        if (pop) begin
            shift_n = fifo_rd;
            par_n   = (^fifo_rd) ^ PAR_FLIP;
        end else if (state == S_DATA && bit_end) begin
            shift_n = shift_reg >> 1;
        end
        if (state_n == S_DATA)
            idx_n = (state == S_DATA && bit_end) ? data_idx + IDX_W'(1) : data_idx;
        if (state_n == S_STOP)
            stop_n = (state == S_STOP && bit_end) ? stop_idx + 1'b1 : stop_idx;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
            S_PARITY: tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_STOP) && (stop_n == 1'(STOP_BITS - 1)) &&
                 (cnt_n == CNT_W'(CLKS_PER_BIT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            data_idx   <= '0;
            stop_idx   <= 1'b0;
            shift_reg  <= '0;
            par_reg    <= 1'b0;
            USB_TX     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            bit_cnt    <= cnt_n;
            data_idx   <= idx_n;
            stop_idx   <= stop_n;
            shift_reg  <= shift_n;
            par_reg    <= par_n;
            USB_TX     <= tx_n;
            busy       <= busy_n;
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8N1, 8E1, 8O1 and 7N2 instances driven from vector tables.
module tb_uart_tx_param;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rts;
    logic [7:0] a_data, p_data;
    logic       a_valid, p_valid;

    logic       a_ready, a_tx, a_busy, a_done;
    logic       b_ready, b_tx, b_busy, b_done;
    logic       c_ready, c_tx, c_busy, c_done;
    logic       d_ready, d_tx, d_busy, d_done;
    logic [2:0] a_cnt, b_cnt, c_cnt, d_cnt;

    uart_tx_param u_a (
        .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
        .USB_RTS(rts), .USB_TX(a_tx), .busy(a_busy), .frame_done(a_done), .fifo_count(a_cnt));

    uart_tx_param #(.CLKS_PER_BIT(4), .PARITY_MODE(PAR_EVEN)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_data(p_data), .tx_valid(p_valid), .tx_ready(b_ready),
        .USB_RTS(rts), .USB_TX(b_tx), .busy(b_busy), .frame_done(b_done), .fifo_count(b_cnt));

    uart_tx_param #(.CLKS_PER_BIT(4), .PARITY_MODE(PAR_ODD)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_data(p_data), .tx_valid(p_valid), .tx_ready(c_ready),
        .USB_RTS(rts), .USB_TX(c_tx), .busy(c_busy), .frame_done(c_done), .fifo_count(c_cnt));

    uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2), .CLKS_PER_BIT(4)) u_d (
        .clk(clk), .rst_n(rst_n), .tx_data(p_data[6:0]), .tx_valid(p_valid), .tx_ready(d_ready),
        .USB_RTS(rts), .USB_TX(d_tx), .busy(d_busy), .frame_done(d_done), .fifo_count(d_cnt));

    int n_vec = 0;
    int n_err = 0;

    logic tx_s   [4][800];
    logic done_s [4][800];
    logic busy_s [4][800];

    // exp[k] is the k-th bit to appear on the line (start bit first)
    typedef struct {
        int          s;
        logic [7:0]  data;
        int          clks;
        int          nbits;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    function automatic logic tx_of(input int s);
        case (s)
            0: return a_tx;
            1: return b_tx;
            2: return c_tx;
            default: return d_tx;
        endcase
    endfunction

    function automatic logic done_of(input int s);
        case (s)
            0: return a_done;
            1: return b_done;
            2: return c_done;
            default: return d_done;
        endcase
    endfunction

    function automatic logic busy_of(input int s);
        case (s)
            0: return a_busy;
            1: return b_busy;
            2: return c_busy;
            default: return d_busy;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int grp, input logic [7:0] d, input logic v);
        if (grp == 0) begin
            a_data  = d;
            a_valid = v;
        end else begin
            p_data  = d;
            p_valid = v;
        end
    endtask

    // Writes n words (w[7:0] first) on n consecutive edges; returns 1 time unit after the last one.
    task automatic write_seq(input int grp, input int n, input logic [39:0] w);
        @(negedge clk);
        set_in(grp, w[7:0], 1'b1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i < n - 1) set_in(grp, w[8*(i+1) +: 8], 1'b1);
            else           set_in(grp, 8'h00, 1'b0);
        end
    endtask

    task automatic capture(input int from, input int n);
        for (int k = from; k < from + n; k++) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) begin
                tx_s[s][k]   = tx_of(s);
                done_s[s][k] = done_of(s);
                busy_s[s][k] = busy_of(s);
            end
        end
    endtask

    task automatic check_frame(input int s, input int first, input int clks, input int nbits,
                               input logic [15:0] exp, input string name);
        int bad_tx, bad_done, bad_busy, last;
        bad_tx = 0; bad_done = 0; bad_busy = 0;
        last = first + clks * nbits - 1;
        for (int k = first; k <= last; k++) begin
            if (tx_s[s][k] !== exp[(k - first) / clks]) bad_tx++;
            if (done_s[s][k] !== (k == last)) bad_done++;
            if (busy_s[s][k] !== 1'b1) bad_busy++;
        end
        chk({name, " line bits (bad cycles)"}, 32'(bad_tx), 32'd0);
        chk({name, " frame_done (bad cycles)"}, 32'(bad_done), 32'd0);
        chk({name, " busy (bad cycles)"}, 32'(bad_busy), 32'd0);
    endtask

    task automatic check_idle(input int s, input int from, input int to, input string name);
        int bad;
        bad = 0;
        for (int k = from; k <= to; k++)
            if ({tx_s[s][k], busy_s[s][k], done_s[s][k]} !== 3'b100) bad++;
        chk({name, " idle (bad cycles)"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int len;
        rst_n = 1'b0; rts = 1'b0;
        a_data = '0; a_valid = 1'b0; p_data = '0; p_valid = 1'b0;

        vecs[0]  = '{0, 8'hAA, 16, 10, 16'h0354};
        vecs[1]  = '{0, 8'h00, 16, 10, 16'h0200};
        vecs[2]  = '{0, 8'hFF, 16, 10, 16'h03FE};
        vecs[3]  = '{0, 8'h35, 16, 10, 16'h026A};
        vecs[4]  = '{1, 8'hCC,  4, 11, 16'h0598};
        vecs[5]  = '{1, 8'h01,  4, 11, 16'h0602};
        vecs[6]  = '{1, 8'h7F,  4, 11, 16'h06FE};
        vecs[7]  = '{2, 8'hCC,  4, 11, 16'h0798};
        vecs[8]  = '{2, 8'h01,  4, 11, 16'h0402};
        vecs[9]  = '{3, 8'h55,  4, 10, 16'h03AA};
        vecs[10] = '{3, 8'h0A,  4, 10, 16'h0314};

        // reset state, then ready from the first edge out of reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset a {tx,busy,done,ready,cnt}", 32'({a_tx, a_busy, a_done, a_ready, a_cnt}), 32'b1000_000);
        chk("reset d {tx,busy,done,ready,cnt}", 32'({d_tx, d_busy, d_done, d_ready, d_cnt}), 32'b1000_000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", 32'({a_ready, b_ready, c_ready, d_ready}), 32'b1111);
        chk("count after reset", 32'(a_cnt), 32'd0);

        for (int i = 0; i < 11; i++) begin
            len = vecs[i].clks * vecs[i].nbits;
            write_seq((vecs[i].s == 0) ? 0 : 1, 1, 40'(vecs[i].data));
            capture(0, len + 9);
            check_idle(vecs[i].s, 0, 0, $sformatf("vec%0d pre-start", i));
            check_frame(vecs[i].s, 1, vecs[i].clks, vecs[i].nbits, vecs[i].exp, $sformatf("vec%0d", i));
            check_idle(vecs[i].s, len + 1, len + 8, $sformatf("vec%0d post", i));
        end

        // FIFO fill under RTS hold-off, fifth write dropped, then four back-to-back frames
        rts = 1'b1;
        write_seq(0, 4, {8'h00, 8'h44, 8'h33, 8'h22, 8'h11});
        @(negedge clk);
        chk("full count", 32'(a_cnt), 32'd4);
        chk("full ready", 32'(a_ready), 32'd0);
        a_data = 8'h55; a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        chk("count after dropped write", 32'(a_cnt), 32'd4);
        rts = 1'b0;
        capture(1, 650);
        check_frame(0, 1,   16, 10, 16'h0222, "fifo f1");
        check_frame(0, 161, 16, 10, 16'h0244, "fifo f2");
        check_frame(0, 321, 16, 10, 16'h0266, "fifo f3");
        check_frame(0, 481, 16, 10, 16'h0288, "fifo f4");
        check_idle(0, 641, 650, "fifo drained");
        chk("count after drain", 32'(a_cnt), 32'd0);

        // RTS raised during data bit 3: frame unaffected, next frame waits for RTS low
        write_seq(0, 2, {24'h0, 8'hA5, 8'h5A});
        capture(1, 69);
        rts = 1'b1;
        chk("queued behind frame", 32'(a_cnt), 32'd1);
        capture(70, 200);
        check_frame(0, 1, 16, 10, 16'h02B4, "rts f1");
        check_idle(0, 161, 269, "rts hold");
        chk("count while held", 32'(a_cnt), 32'd1);
        rts = 1'b0;
        capture(270, 170);
        check_frame(0, 270, 16, 10, 16'h034A, "rts f2");
        check_idle(0, 430, 439, "rts after f2");

        // reset during a data bit with two words queued
        write_seq(0, 3, {16'h0, 8'h33, 8'h22, 8'h11});
        @(negedge clk);
        chk("simultaneous write/pop count", 32'(a_cnt), 32'd2);
        repeat (38) @(negedge clk);
        chk("busy before abort", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort {tx,busy,done,cnt}", 32'({a_tx, a_busy, a_done, a_cnt}), 32'b100_000);
        rst_n = 1'b1;
        capture(0, 200);
        check_idle(0, 0, 199, "after abort");
        chk("count after abort", 32'(a_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal minimum 2.
REQ-003 Parameter PARITY_MODE, default PAR_NONE: one of PAR_NONE, PAR_EVEN, PAR_ODD.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of 2, at least 2.
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 tx_data  in  DATA_BITS  byte to send; sampled when tx_valid & tx_ready.
REQ-009 tx_valid  in  1  producer offers tx_data.
REQ-010 tx_ready  out  1  FIFO not full.
REQ-011 USB_RTS  in  1  flow control; 0 = host accepts data, 1 = hold off.
REQ-012 USB_TX  out  1  serial line, registered; idle high.
REQ-013 busy  out  1  frame in progress.
REQ-014 frame_done  out  1  one-cycle pulse at frame end.
REQ-015 fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued.

Function
REQ-016 A write occurs on each edge with tx_valid=1 and tx_ready=1; tx_ready = (fifo_count != FIFO_DEPTH); a write while full is dropped, and the FIFO is unchanged.
REQ-017 A simultaneous write and pop leaves fifo_count unchanged; FIFO order is strictly first-in first-out.
REQ-018 FSM states are S_IDLE, S_START, S_DATA, S_PARITY and S_STOP.
REQ-019 In S_IDLE, USB_TX=1 and busy=0; at an edge where fifo_count>0 and USB_RTS=0, the FSM pops one entry into the shift register, drives USB_TX=0 from that edge, and enters S_START.
REQ-020 Latency: a word written at edge t into an empty FIFO with USB_RTS=0 and the FSM idle starts its start bit at edge t+1.
REQ-021 Every bit (start, data, parity, stop) is held exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads at each bit boundary.
REQ-022 Data is sent LSB first, DATA_BITS bits, then S_PARITY only if PARITY_MODE != PAR_NONE, then STOP_BITS stop bits at 1.
REQ-023 Parity bit = XOR of all data bits for PAR_EVEN, or its inverse for PAR_ODD, computed from the popped word.
REQ-024 Frame length = CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) cycles, where P = 1 if parity is enabled, else 0.
REQ-025 USB_RTS is sampled only in S_IDLE and at the final stop-bit cycle; raising USB_RTS mid-frame never truncates or stretches the current frame.
REQ-026 On the last cycle of the final stop bit, frame_done=1 for one cycle; if fifo_count>0 and USB_RTS=0 on that cycle, the next start bit follows at the next edge with no idle cycle; otherwise the FSM returns to S_IDLE.
REQ-027 busy=1 from the pop edge through the last stop-bit cycle inclusive.
REQ-028 Illegal parameter values cause an elaboration-time error.

Reset
REQ-029 While rst_n=0 at an edge: FSM enters S_IDLE, USB_TX=1, busy=0, frame_done=0, fifo_count=0, tx_ready=0, and the bit counter and shift register are cleared.
REQ-030 tx_ready=1 from the first edge with rst_n=1.
REQ-031 Reset mid-frame aborts the frame; USB_TX is high at the next edge, and queued data is discarded.

Structure
REQ-032 Package uart_pkg holds the parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD), the state enum, and the protocol constants ACK=8'hAA and RESEND=8'hCC.
REQ-033 The FIFO is a separate sub-module, uart_fifo, parametrised by width and depth; uart_tx_param instantiates it once.

Verification
REQ-034 Defaults, send 8'hAA with USB_RTS=0 -> USB_TX 0 for 16 cycles, bits 0,1,0,1,0,1,0,1 at 16 cycles each, then 1 for 16 cycles; frame_done at frame cycle 160.
REQ-035 PAR_EVEN, send 8'hCC -> parity bit 0; PAR_ODD, send 8'hCC -> parity bit 1; PAR_EVEN, send 8'h01 -> parity bit 1.
REQ-036 FIFO_DEPTH=4, five consecutive writes while USB_RTS=1 -> fifth dropped with tx_ready=0; after USB_RTS falls, four frames back-to-back with zero idle cycles, in order.
REQ-037 USB_RTS raised during data bit 3 -> frame completes unchanged; the queued frame waits; USB_RTS low at edge e -> start bit at edge e.
REQ-038 rst_n low during a data bit with 2 words queued -> USB_TX=1, busy=0, fifo_count=0 next edge, and no frame_done.
REQ-039 DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4, PAR_NONE -> frame of 40 cycles, with USB_TX high for the last 8.
